pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Drives enable/flush of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, taken-branch squash,
// data-memory wait states with timeout, and saturating debug counters.

module phc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             pc_sel_branch,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic pc_sel_branch;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 9'b1111_0_0000;
  localparam ctrl_t CTRL_FREEZE = 9'b0000_0_0001;
  localparam ctrl_t CTRL_HALT   = 9'b0000_0_1111;

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    timeout_q, timeout_d;
  ctrl_t                   ctrl, ctrl_o;
  logic                    hold, load_use;
  logic [1:0]              cnt_inc;
  logic [1:0][CNT_W-1:0]   cnt_q;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    ctrl      = CTRL_RUN;
    cnt_inc   = '0;
    hold      = 1'b0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        // Once waiting, EX/MEM is frozen, so only dmem_ready decides release.
        hold = !dmem_ready && (state_q == MEM_WAIT || mem_access);
        if (hold) begin
          ctrl       = CTRL_FREEZE;
          cnt_inc[0] = 1'b1;
          if (state_q == RUN) begin
            wait_d  = WAIT_W'(1);
            state_d = MEM_WAIT;
          end else if (wait_q == WAIT_MAX) begin
            wait_d    = '0;
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          // A branch held in EX/MEM during a wait is taken here on release.
          state_d = RUN;
          wait_d  = '0;
          if (mem_branch_taken) begin
            ctrl.pc_sel_branch = 1'b1;
            ctrl.ifid_flush    = 1'b1;
            ctrl.idex_flush    = 1'b1;
            ctrl.exmem_flush   = 1'b1;
            cnt_inc[1]         = 1'b1;
          end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
            cnt_inc[0]      = 1'b1;
          end
        end
      end
      default: ctrl = CTRL_HALT;
    endcase
  end

  assign ctrl_o = rst_n ? ctrl : CTRL_HALT;

  assign pc_en         = ctrl_o.pc_en;
  assign ifid_en       = ctrl_o.ifid_en;
  assign idex_en       = ctrl_o.idex_en;
  assign exmem_en      = ctrl_o.exmem_en;
  assign pc_sel_branch = ctrl_o.pc_sel_branch;
  assign ifid_flush    = ctrl_o.ifid_flush;
  assign idex_flush    = ctrl_o.idex_flush;
  assign exmem_flush   = ctrl_o.exmem_flush;
  assign memwb_bubble  = ctrl_o.memwb_bubble;
  assign timeout_err   = timeout_q;

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    phc_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[g]),
      .cnt   (cnt_q[g])
    );
  end

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// expected responses from a cycle-level reference model.

module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 5;
  localparam int CMAX        = (1 << CNT_W) - 1;

  // {pc,ifid,idex,exmem en, pc_sel_branch, ifid,idex,exmem flush, memwb_bubble}
  localparam logic [8:0] C_RUN    = 9'b1111_0_0000;
  localparam logic [8:0] C_FREEZE = 9'b0000_0_0001;
  localparam logic [8:0] C_HALT   = 9'b0000_0_1111;
  localparam logic [8:0] C_BR     = 9'b1111_1_1110;
  localparam logic [8:0] C_LU     = 9'b0011_0_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memread = 1'b0;
  logic mem_branch_taken = 1'b0, mem_access = 1'b0, dmem_ready = 1'b1;
  logic pc_en, ifid_en, idex_en, exmem_en, pc_sel_branch;
  logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .pc_sel_branch(pc_sel_branch), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] ctrl;
    logic       terr;
    int         stall;
    int         flush;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;

  // Reference model: count of consecutive frozen cycles, a dead flag, event totals.
  int m_frozen = 0, m_stall = 0, m_flush = 0;
  bit m_dead = 1'b0;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic bit reads_reg(input logic [4:0] r);
    bit hit = 1'b0;
    if (r == 5'd0) return 1'b0;
    if (id_use_rs1 && id_rs1 == r) hit = 1'b1;
    if (id_use_rs2 && id_rs2 == r) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_step(input string tag, output exp_t e);
    if (!rst_n) begin
      m_frozen = 0; m_stall = 0; m_flush = 0; m_dead = 1'b0;
    end
    e.tag = tag; e.stall = m_stall; e.flush = m_flush; e.terr = m_dead;
    if (!rst_n || m_dead) begin
      e.ctrl = C_HALT;
    end else if (!dmem_ready && (m_frozen > 0 || mem_access)) begin
      e.ctrl   = C_FREEZE;
      m_frozen = m_frozen + 1;
      m_stall  = sat(m_stall);
      if (m_frozen > MEM_TIMEOUT) m_dead = 1'b1;
    end else begin
      m_frozen = 0;
      if (mem_branch_taken) begin
        e.ctrl  = C_BR;
        m_flush = sat(m_flush);
      end else if (ex_memread && reads_reg(ex_rd)) begin
        e.ctrl  = C_LU;
        m_stall = sat(m_stall);
      end else begin
        e.ctrl = C_RUN;
      end
    end
  endtask

  task automatic drive(input string tag, input logic rn, ma, rdy, br, mr,
                       input logic [4:0] rd, r1, r2, input logic u1, u2);
    exp_t e;
    @(negedge clk);
    rst_n = rn; mem_access = ma; dmem_ready = rdy; mem_branch_taken = br;
    ex_memread = mr; ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    model_step(tag, e);
    sbq.push_back(e);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are combinational, so sample late in the low phase.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk); #4;
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = {pc_en, ifid_en, idex_en, exmem_en, pc_sel_branch,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble};
        n_chk += 4;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL %s ctrl: got %b want %b @%0t", e.tag, act, e.ctrl, $time);
        end
        if (timeout_err !== e.terr) begin
          n_fail++;
          $display("FAIL %s timeout_err: got %b want %b @%0t", e.tag, timeout_err, e.terr, $time);
        end
        if (int'(stall_cnt) != e.stall) begin
          n_fail++;
          $display("FAIL %s stall_cnt: got %0d want %0d @%0t", e.tag, stall_cnt, e.stall, $time);
        end
        if (int'(flush_cnt) != e.flush) begin
          n_fail++;
          $display("FAIL %s flush_cnt: got %0d want %0d @%0t", e.tag, flush_cnt, e.flush, $time);
        end
      end
    end
  end

  initial begin
    // reset, then release to RUN defaults
    drive("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("reset", 0, 1, 0, 1, 1, 5, 5, 5, 1, 1);
    idle("post_reset", 2);
    // load-use on rs2: exactly one bubble
    drive("load_use", 1, 0, 1, 0, 1, 5, 3, 5, 0, 1);
    idle("load_use_after", 1);
    // rs1==rs2==ex_rd, then ex_rd==0 never stalls, then unused operand match
    drive("lu_both", 1, 0, 1, 0, 1, 7, 7, 7, 1, 1);
    drive("lu_rd0", 1, 0, 1, 0, 1, 0, 0, 0, 1, 1);
    drive("lu_unused", 1, 0, 1, 0, 1, 9, 9, 9, 0, 0);
    // branch beats load-use
    drive("branch", 1, 0, 1, 1, 1, 5, 5, 0, 1, 0);
    idle("branch_after", 1);
    // memory wait: three frozen cycles, release on the fourth
    for (int i = 0; i < 3; i++) drive("mem_wait", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("mem_release", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // branch held through a wait and taken on release
    for (int i = 0; i < 2; i++) drive("br_in_wait", 1, 1, 0, 1, 1, 4, 4, 0, 1, 0);
    drive("br_release", 1, 1, 1, 1, 1, 4, 4, 0, 1, 0);
    // reset in the middle of a wait leaves nothing pending
    for (int i = 0; i < 2; i++) drive("wait_pre_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("mid_wait_rst", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    drive("after_rst", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle("after_rst_idle", 1);
    // timeout: ready never comes, then ready is ignored until reset
    for (int i = 0; i < MEM_TIMEOUT + 4; i++) drive("timeout", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive("timeout_sticky", 1, 1, 1, 1, 1, 2, 2, 2, 1, 1);
    drive("timeout_rst", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("timeout_clear", 2);
    // random traffic with small register indices for frequent matches
    for (int i = 0; i < 3000; i++)
      drive("random", ($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2), $urandom_range(0, 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1), $urandom_range(0, 1));
    idle("drain", 2);
    @(negedge clk); #6;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
